// File: rtl/buf_pkg.sv
`default_nettype none
// ==========================================================================
// buf_pkg: shared constants, FSM state type and round-robin search helper
// Rev 1.0
// ==========================================================================
package buf_pkg;

  localparam int DATA_W    = 16;
  localparam int BUF_DEPTH = 8;
  localparam int c_rr_max  = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // First set bit of valid_vec strictly after last_grant, wrapping modulo n_req;
  // last_grant itself is the final candidate, so a lone requester can win again.
  function automatic logic [2:0] rr_next(input logic [c_rr_max-1:0] valid_vec,
                                         input logic [2:0]          last_grant,
                                         input int unsigned         n_req);
    logic [2:0]  pick;
    logic        found;
    int unsigned idx;
    pick  = last_grant;
    found = 1'b0;
    for (int unsigned k = 1; k <= c_rr_max; k++) begin
      idx = (32'(last_grant) + k) % n_req;
      if (!found && (k <= n_req) && valid_vec[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ==========================================================================
// rr_pick: combinational cyclic priority search over N_REQ valid lines
// Rev 1.0
// ==========================================================================
module rr_pick
#(
  parameter int N_REQ = 4,
  parameter int GW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_valid,
  input  logic [GW-1:0]    i_last_grant,
  output logic [GW-1:0]    o_grant
);
  import buf_pkg::*;

  logic [c_rr_max-1:0] w_valid_pad;
  logic [2:0]          w_last_pad;
  logic [2:0]          w_pick;

  always_comb begin
    w_valid_pad              = '0;
    w_valid_pad[N_REQ-1:0]   = i_valid;
    w_last_pad               = 3'(i_last_grant);
    w_pick                   = rr_next(w_valid_pad, w_last_pad, N_REQ);
  end

  assign o_grant = GW'(w_pick);

endmodule
`default_nettype wire

// File: rtl/buffer_write_arbiter.sv
`default_nettype none
// ==========================================================================
// buffer_write_arbiter: round-robin packet arbiter for the clk_1 buffer write port
// Rev 1.0
// ==========================================================================
module buffer_write_arbiter
#(
  parameter int   N_REQ     = 4,
  parameter int   DATA_W    = buf_pkg::DATA_W,
  parameter int   MAX_BURST = 8,
  parameter int   TIMEOUT   = 16,
  localparam int  GW        = $clog2(N_REQ)
) (
  input  logic                    clk_1,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        i_req_valid,
  input  logic [N_REQ-1:0]        i_req_last,
  input  logic [N_REQ*DATA_W-1:0] i_req_data,
  output logic [N_REQ-1:0]        o_req_ready,
  input  logic                    i_buf_full,
  output logic [DATA_W-1:0]       o_buf_data,
  output logic                    o_buf_wr_en,
  output logic [GW-1:0]           o_grant_id,
  output logic                    o_busy,
  output logic                    o_timeout_p
);
  import buf_pkg::*;

  localparam logic [GW-1:0] c_last_id = GW'(N_REQ - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [GW-1:0]      r_grant_id;
  logic [GW-1:0]      w_grant_nxt;
  logic [GW-1:0]      w_pick;
  logic [7:0]         r_beat_cnt;
  logic [7:0]         w_beat_nxt;
  logic [7:0]         r_idle_cnt;
  logic [7:0]         w_idle_nxt;
  logic               r_busy;
  logic               r_timeout_p;
  logic               w_timeout_nxt;
  logic               w_cur_valid;
  logic               w_cur_last;
  logic               w_accept;
  logic [DATA_W-1:0]  w_req_beat [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign w_req_beat[gi] = i_req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .i_valid      (i_req_valid),
    .i_last_grant (r_grant_id),
    .o_grant      (w_pick)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant_id;
    w_beat_nxt    = r_beat_cnt;
    w_idle_nxt    = r_idle_cnt;
    w_timeout_nxt = 1'b0;
    w_cur_valid   = i_req_valid[r_grant_id];
    w_cur_last    = i_req_last[r_grant_id];
    w_accept      = 1'b0;
    o_req_ready   = '0;
    o_buf_wr_en   = 1'b0;
    o_buf_data    = '0;
    case (r_state)
      IDLE: begin
        w_beat_nxt = 8'd0;
        w_idle_nxt = 8'd0;
        if (|i_req_valid) begin
          w_state_nxt = BURST;
          w_grant_nxt = w_pick;
        end
      end
      BURST: begin
        o_req_ready[r_grant_id] = ~i_buf_full;
        w_accept                = w_cur_valid & ~i_buf_full;
        if (w_accept) begin
          o_buf_wr_en = 1'b1;
          o_buf_data  = w_req_beat[r_grant_id];
          w_beat_nxt  = r_beat_cnt + 8'd1;
          w_idle_nxt  = 8'd0;
          if (w_cur_last || (({1'b0, r_beat_cnt} + 9'd1) == 9'(MAX_BURST))) begin
            w_state_nxt = IDLE;
          end
        // idle_cnt would reach TIMEOUT-1 with this stalled cycle: release now
        end else if (({1'b0, r_idle_cnt} + 9'd2) >= 9'(TIMEOUT)) begin
          w_state_nxt   = IDLE;
          w_timeout_nxt = 1'b1;
        end else begin
          w_idle_nxt = r_idle_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_grant_id  <= c_last_id;
      r_beat_cnt  <= 8'd0;
      r_idle_cnt  <= 8'd0;
      r_busy      <= 1'b0;
      r_timeout_p <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant_id  <= w_grant_nxt;
      r_beat_cnt  <= w_beat_nxt;
      r_idle_cnt  <= w_idle_nxt;
      r_busy      <= (w_state_nxt == BURST);
      r_timeout_p <= w_timeout_nxt;
    end
  end

  assign o_grant_id  = r_grant_id;
  assign o_busy      = r_busy;
  assign o_timeout_p = r_timeout_p;

endmodule
`default_nettype wire

// File: tb/tb_buffer_write_arbiter.sv
`default_nettype none
// ==========================================================================
// tb_buffer_write_arbiter: directed vector table plus producer-model sequences
// Rev 1.0
// ==========================================================================
`timescale 1ns/1ps
module tb_buffer_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;

  logic            clk_1 = 1'b0;
  logic            rst   = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_last  = '0;
  logic [N*DW-1:0] req_data  = '0;
  logic [N-1:0]    req_ready;
  logic            buf_full  = 1'b0;
  logic [DW-1:0]   buf_data;
  logic            buf_wr_en;
  logic [1:0]      grant_id;
  logic            busy;
  logic            timeout_p;

  always #5 clk_1 = ~clk_1;

  buffer_write_arbiter #(
    .N_REQ     (N),
    .DATA_W    (DW),
    .MAX_BURST (8),
    .TIMEOUT   (16)
  ) dut (
    .clk_1       (clk_1),
    .rst         (rst),
    .i_req_valid (req_valid),
    .i_req_last  (req_last),
    .i_req_data  (req_data),
    .o_req_ready (req_ready),
    .i_buf_full  (buf_full),
    .o_buf_data  (buf_data),
    .o_buf_wr_en (buf_wr_en),
    .o_grant_id  (grant_id),
    .o_busy      (busy),
    .o_timeout_p (timeout_p)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          rst_before;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic        full;
    logic [63:0] data;
    logic [3:0]  e_ready;
    logic        e_wr;
    logic [15:0] e_data;
    logic [1:0]  e_gid;
    logic        e_busy;
    logic        e_to;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit rb, input logic [3:0] v, input logic [3:0] l,
                              input logic [15:0] d0, input logic [15:0] d2,
                              input logic [3:0] er, input logic ew, input logic [15:0] ed,
                              input logic [1:0] eg, input logic eb);
    vec_t r;
    r.rst_before = rb;
    r.valid      = v;
    r.last       = l;
    r.full       = 1'b0;
    r.data       = {16'h0, d2, 16'h0, d0};
    r.e_ready    = er;
    r.e_wr       = ew;
    r.e_data     = ed;
    r.e_gid      = eg;
    r.e_busy     = eb;
    r.e_to       = 1'b0;
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk_1);
    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    buf_full  = 1'b0;
    repeat (2) @(negedge clk_1);
    rst = 1'b0;
  endtask

  // Producer model state
  int rem[N], sent[N], pause_after[N], pause_len[N], pcnt[N];
  bit use_last[N];
  int full_from, full_len, cyc;
  int seg_id[$], seg_len[$];
  bit prev_acc;
  int prev_id, to_cnt, to_gap, last_acc_cyc, wr_cnt;

  task automatic init_model();
    for (int i = 0; i < N; i++) begin
      rem[i] = 0; sent[i] = 0; pause_after[i] = -1; pause_len[i] = 0; pcnt[i] = 0;
      use_last[i] = 1'b0;
    end
    full_from = -1; full_len = 0; cyc = 0;
    seg_id.delete(); seg_len.delete();
    prev_acc = 1'b0; prev_id = -1; to_cnt = 0; to_gap = -1; last_acc_cyc = -1; wr_cnt = 0;
  endtask

  task automatic run_model(input int ncyc);
    logic [DW-1:0] d [N];
    logic [N-1:0]  v, l, acc;
    logic          f;
    bit            paused;
    int            id;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk_1);
      for (int i = 0; i < N; i++) begin
        paused = (pause_after[i] >= 0) && (sent[i] == pause_after[i]) && (pcnt[i] < pause_len[i]);
        if (paused) pcnt[i]++;
        v[i] = (rem[i] > 0) && !paused;
        l[i] = use_last[i] && (rem[i] == 1);
        d[i] = {4'(i), 12'(sent[i])};
        req_data[i*DW +: DW] = d[i];
      end
      f = (cyc >= full_from) && (cyc < full_from + full_len);
      req_valid = v;
      req_last  = l;
      buf_full  = f;
      #1;
      acc = req_ready & v;
      chk($sformatf("c%0d_wr_en", cyc), buf_wr_en, |acc);
      chk($sformatf("c%0d_ready_onehot", cyc), $countones(req_ready) <= 1, 1);
      if (f) begin
        chk($sformatf("c%0d_full_ready", cyc), req_ready, 0);
        chk($sformatf("c%0d_full_busy", cyc), busy, 1);
      end
      if (|acc) begin
        id = 0;
        for (int i = 0; i < N; i++) if (acc[i]) id = i;
        chk($sformatf("c%0d_data", cyc), buf_data, d[id]);
        sent[id]++;
        rem[id]--;
        wr_cnt++;
        last_acc_cyc = cyc;
        if (prev_acc && prev_id == id) seg_len[seg_len.size()-1]++;
        else begin
          seg_id.push_back(id);
          seg_len.push_back(1);
        end
        prev_id = id;
      end
      prev_acc = |acc;
      if (timeout_p) begin
        to_cnt++;
        to_gap = cyc - last_acc_cyc;
      end
      cyc++;
    end
  endtask

  task automatic check_seg(input string tag, input int k, input int id, input int len);
    if (k < seg_id.size()) begin
      chk({tag, "_id"}, seg_id[k], id);
      chk({tag, "_len"}, seg_len[k], len);
    end else begin
      chk({tag, "_present"}, seg_id.size(), k + 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single-requester packet, then two requesters alternating 2-beat packets
    tbl.push_back(mk(1, 4'b0001, 4'b0000, 16'h00AA, 16'h0,    4'b0000, 0, 16'h0,    2'd3, 0));
    tbl.push_back(mk(0, 4'b0001, 4'b0000, 16'h00AA, 16'h0,    4'b0001, 1, 16'h00AA, 2'd0, 1));
    tbl.push_back(mk(0, 4'b0001, 4'b0000, 16'h00BB, 16'h0,    4'b0001, 1, 16'h00BB, 2'd0, 1));
    tbl.push_back(mk(0, 4'b0001, 4'b0001, 16'h00CC, 16'h0,    4'b0001, 1, 16'h00CC, 2'd0, 1));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 16'h0,    16'h0,    4'b0000, 0, 16'h0,    2'd0, 0));
    tbl.push_back(mk(1, 4'b0101, 4'b0000, 16'h00A1, 16'h20A1, 4'b0000, 0, 16'h0,    2'd3, 0));
    tbl.push_back(mk(0, 4'b0101, 4'b0000, 16'h00A1, 16'h20A1, 4'b0001, 1, 16'h00A1, 2'd0, 1));
    tbl.push_back(mk(0, 4'b0101, 4'b0001, 16'h00B1, 16'h20A1, 4'b0001, 1, 16'h00B1, 2'd0, 1));
    tbl.push_back(mk(0, 4'b0101, 4'b0000, 16'h00A2, 16'h20A1, 4'b0000, 0, 16'h0,    2'd0, 0));
    tbl.push_back(mk(0, 4'b0101, 4'b0000, 16'h00A2, 16'h20A1, 4'b0100, 1, 16'h20A1, 2'd2, 1));
    tbl.push_back(mk(0, 4'b0101, 4'b0100, 16'h00A2, 16'h20B1, 4'b0100, 1, 16'h20B1, 2'd2, 1));
    tbl.push_back(mk(0, 4'b0101, 4'b0000, 16'h00A2, 16'h20A2, 4'b0000, 0, 16'h0,    2'd2, 0));
    tbl.push_back(mk(0, 4'b0101, 4'b0000, 16'h00A2, 16'h20A2, 4'b0001, 1, 16'h00A2, 2'd0, 1));
    tbl.push_back(mk(0, 4'b0101, 4'b0001, 16'h00B2, 16'h20A2, 4'b0001, 1, 16'h00B2, 2'd0, 1));
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 16'h0,    16'h20A2, 4'b0000, 0, 16'h0,    2'd0, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 16'h0,    16'h20A2, 4'b0100, 1, 16'h20A2, 2'd2, 1));
    tbl.push_back(mk(0, 4'b0100, 4'b0100, 16'h0,    16'h20B2, 4'b0100, 1, 16'h20B2, 2'd2, 1));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 16'h0,    16'h0,    4'b0000, 0, 16'h0,    2'd2, 0));

    // Reset values, sampled after a clock edge with rst held high
    repeat (2) @(negedge clk_1);
    #1;
    chk("reset_ready", req_ready, 0);
    chk("reset_wr_en", buf_wr_en, 0);
    chk("reset_data", buf_data, 0);
    chk("reset_grant_id", grant_id, 3);
    chk("reset_busy", busy, 0);
    chk("reset_timeout", timeout_p, 0);

    for (int k = 0; k < tbl.size(); k++) begin
      if (tbl[k].rst_before) do_reset();
      @(negedge clk_1);
      req_valid = tbl[k].valid;
      req_last  = tbl[k].last;
      req_data  = tbl[k].data;
      buf_full  = tbl[k].full;
      #1;
      chk($sformatf("vec%0d_ready", k), req_ready, tbl[k].e_ready);
      chk($sformatf("vec%0d_wr_en", k), buf_wr_en, tbl[k].e_wr);
      chk($sformatf("vec%0d_data", k), buf_data, tbl[k].e_data);
      chk($sformatf("vec%0d_grant_id", k), grant_id, tbl[k].e_gid);
      chk($sformatf("vec%0d_busy", k), busy, tbl[k].e_busy);
      chk($sformatf("vec%0d_timeout", k), timeout_p, tbl[k].e_to);
    end

    // req1 streams 20 unterminated beats, req3 has one 2-beat packet
    do_reset();
    init_model();
    rem[1] = 20;
    rem[3] = 2; use_last[3] = 1'b1;
    run_model(50);
    chk("t3_seg_count", seg_id.size(), 4);
    check_seg("t3_seg0", 0, 1, 8);
    check_seg("t3_seg1", 1, 3, 2);
    check_seg("t3_seg2", 2, 1, 8);
    check_seg("t3_seg3", 3, 1, 4);
    chk("t3_sent1", sent[1], 20);
    chk("t3_sent3", sent[3], 2);
    chk("t3_timeouts", to_cnt, 1);

    // buf_full high for 5 cycles inside a 6-beat packet
    do_reset();
    init_model();
    rem[0] = 6; use_last[0] = 1'b1;
    full_from = 3; full_len = 5;
    run_model(20);
    chk("t4_seg_count", seg_id.size(), 2);
    check_seg("t4_seg0", 0, 0, 2);
    check_seg("t4_seg1", 1, 0, 4);
    chk("t4_beats", wr_cnt, 6);
    chk("t4_timeouts", to_cnt, 0);

    // grantee stalls 20 cycles after 2 beats; req1 waits behind it
    do_reset();
    init_model();
    rem[0] = 4; use_last[0] = 1'b1; pause_after[0] = 2; pause_len[0] = 20;
    rem[1] = 1; use_last[1] = 1'b1;
    run_model(40);
    chk("t5_timeouts", to_cnt, 1);
    chk("t5_timeout_gap", to_gap, 16);
    chk("t5_seg_count", seg_id.size(), 3);
    check_seg("t5_seg0", 0, 0, 2);
    check_seg("t5_seg1", 1, 1, 1);
    check_seg("t5_seg2", 2, 0, 2);
    chk("t5_sent0", sent[0], 4);

    // rst asserted during the second beat of a req2 burst
    do_reset();
    @(negedge clk_1);
    req_valid = 4'b0100; req_last = '0; req_data[2*DW +: DW] = 16'h2AA0;
    #1;
    chk("t6_arb_wr_en", buf_wr_en, 0);
    @(negedge clk_1);
    #1;
    chk("t6_b0_wr_en", buf_wr_en, 1);
    chk("t6_b0_data", buf_data, 16'h2AA0);
    chk("t6_b0_grant_id", grant_id, 2);
    @(negedge clk_1);
    req_data[2*DW +: DW] = 16'h2AA1;
    #1;
    chk("t6_b1_data", buf_data, 16'h2AA1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_wr_en", buf_wr_en, 0);
    chk("t6_rst_ready", req_ready, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_grant_id", grant_id, 3);
    chk("t6_rst_data", buf_data, 0);
    chk("t6_rst_timeout", timeout_p, 0);
    @(negedge clk_1);
    #1;
    chk("t6_hold_wr_en", buf_wr_en, 0);
    req_valid = '0;
    rst = 1'b0;
    @(negedge clk_1);
    req_valid = 4'b0101; req_data[DW-1:0] = 16'h0BB0;
    #1;
    chk("t6_post_idle_wr_en", buf_wr_en, 0);
    @(negedge clk_1);
    #1;
    chk("t6_post_grant_id", grant_id, 0);
    chk("t6_post_ready", req_ready, 4'b0001);
    chk("t6_post_data", buf_data, 16'h0BB0);
    @(negedge clk_1);
    req_valid = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
